// File: rtl/dmro_serializer_pkg.sv
// Shared constants for the ETROC1 readout serializer.
// Holds the frame header, PRBS seed, scrambler/PRBS tap positions, word and
// payload widths, and a payload bit-reversal helper.
package dmro_pkg;

    localparam int unsigned WORD_BITS = 32;
    localparam int unsigned DATA_BITS = 30;

    localparam logic [1:0] HEADER    = 2'b10;
    localparam logic [6:0] PRBS_SEED = 7'h7F;

    // Scrambler x^58+x^39+1: feedback from state bits 57 and 38.
    localparam int unsigned SCR_BITS   = 58;
    localparam int unsigned SCR_TAP_HI = 57;
    localparam int unsigned SCR_TAP_LO = 38;

    // PRBS7 x^7+x^6+1: feedback from state bits 6 and 5.
    localparam int unsigned PRBS_TAP_HI = 6;
    localparam int unsigned PRBS_TAP_LO = 5;

    function automatic logic [DATA_BITS-1:0] bit_reverse(input logic [DATA_BITS-1:0] d);
        logic [DATA_BITS-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < DATA_BITS; i++) begin
            r[i] = d[DATA_BITS-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/dmro_serializer_if.sv
// Bus bundle between the readout logic and the serializer.
// master: drives REVData, REVCLK, ENScr, TestMode, DataIn; receives WordStart, DataOut.
// slave : the serializer side of the same signals.
interface dmro_serializer_if;
    import dmro_pkg::*;

    logic                 REVData;
    logic                 REVCLK;
    logic                 ENScr;
    logic                 TestMode;
    logic [DATA_BITS-1:0] DataIn;
    logic                 WordStart;
    logic                 DataOut;

    modport master (
        output REVData, REVCLK, ENScr, TestMode, DataIn,
        input  WordStart, DataOut
    );

    modport slave (
        input  REVData, REVCLK, ENScr, TestMode, DataIn,
        output WordStart, DataOut
    );

endinterface

// File: rtl/dmro_serializer_prbs7_word.sv
// Word-wide PRBS7 (x^7+x^6+1) generator.
// Ports: clk, rst (sync, active-high, loads SEED), step (advance 32 bit-steps),
//        word (the next 32 PRBS bits, first generated bit in word[31]).
module dmro_prbs7_word
    import dmro_pkg::*;
#(
    parameter logic [6:0] SEED = PRBS_SEED
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 step,
    output logic [WORD_BITS-1:0] word
);

    logic [6:0] state;
    logic [6:0] state_next;

    // Unroll 32 serial LFSR steps; the word is valid before the strobe edge.
    always_comb begin : walk
        logic [6:0] s;
        logic       b;
        word       = '0;
        s          = state;
        b          = 1'b0;
        for (int unsigned k = 0; k < WORD_BITS; k++) begin
            b                   = s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO];
            word[WORD_BITS-1-k] = b;
            s                   = {s[5:0], b};
        end
        state_next = s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (step) begin
            state <= state_next;
        end
    end

endmodule

// File: rtl/dmro_serializer.sv
// ETROC1 readout data serializer.
// Every 32 clocks captures a 30-bit word, optionally reverses/scrambles it,
// prefixes a header and shifts the 32-bit frame out MSB-first. Test mode sends
// PRBS7 words instead.
// Ports: CLKBit (bit clock), RST (sync, active-high),
//        bus (slave modport: REVData, REVCLK, ENScr, TestMode, DataIn in;
//             WordStart, DataOut out).
module dmro_serializer
    import dmro_pkg::*;
#(
    parameter logic [1:0] HEADER    = dmro_pkg::HEADER,
    parameter logic [6:0] PRBS_SEED = dmro_pkg::PRBS_SEED
) (
    input  logic              CLKBit,
    input  logic              RST,
    dmro_serializer_if.slave  bus
);

    logic [4:0]           count;
    logic                 word_start;
    logic [WORD_BITS-1:0] cap_frame;
    logic [WORD_BITS-1:0] shift_reg;
    logic [WORD_BITS-1:0] new_frame;
    logic [WORD_BITS-1:0] prbs_word;
    logic [SCR_BITS-1:0]  scr_state;
    logic [SCR_BITS-1:0]  scr_next;
    logic [DATA_BITS-1:0] payload;
    logic [DATA_BITS-1:0] scr_payload;
    logic                 dout_d;

    assign word_start = (count == 5'd31);

    dmro_prbs7_word #(
        .SEED (PRBS_SEED)
    ) u_prbs (
        .clk  (CLKBit),
        .rst  (RST),
        .step (word_start),
        .word (prbs_word)
    );

    assign payload = bus.REVData ? bit_reverse(bus.DataIn) : bus.DataIn;

    // Scrambler unrolled over one word in transmit order (bit 29 first). The
    // state always absorbs the transmitted bit so it stays in step with a
    // remote descrambler even while scrambling is disabled.
    always_comb begin : scramble
        logic [SCR_BITS-1:0] s;
        logic                o;
        int unsigned         i;
        scr_payload = '0;
        s           = scr_state;
        o           = 1'b0;
        i           = 0;
        for (int unsigned k = 0; k < DATA_BITS; k++) begin
            i              = DATA_BITS - 1 - k;
            o              = payload[i] ^ (bus.ENScr & (s[SCR_TAP_LO] ^ s[SCR_TAP_HI]));
            scr_payload[i] = o;
            s              = {s[SCR_BITS-2:0], o};
        end
        scr_next = s;
    end

    assign new_frame = bus.TestMode ? prbs_word : {HEADER, scr_payload};

    // Two-deep frame pipeline: the capture register decouples DataIn timing
    // from the frame currently on the wire.
    always_ff @(posedge CLKBit) begin
        if (RST) begin
            count     <= '0;
            cap_frame <= '0;
            shift_reg <= '0;
            scr_state <= '0;
            dout_d    <= 1'b0;
        end else begin
            count  <= count + 5'd1;
            dout_d <= shift_reg[WORD_BITS-1];
            if (word_start) begin
                shift_reg <= cap_frame;
                cap_frame <= new_frame;
                scr_state <= scr_next;
            end else begin
                shift_reg <= {shift_reg[WORD_BITS-2:0], 1'b0};
            end
        end
    end

    assign bus.WordStart = word_start;
    assign bus.DataOut   = bus.REVCLK ? dout_d : shift_reg[WORD_BITS-1];

endmodule

// File: tb/tb_dmro_serializer.sv
// Self-checking bench for dmro_serializer: a bit-queue reference model built
// from the frame rules, plus scenario checks (header/ones, bit reversal,
// descrambling, PRBS start, REVCLK delay, mid-frame reset).
module tb_dmro_serializer;

    logic CLKBit = 1'b0;
    logic RST;

    dmro_serializer_if bus ();

    dmro_serializer #(
        .HEADER    (2'b10),
        .PRBS_SEED (7'h7F)
    ) dut (
        .CLKBit (CLKBit),
        .RST    (RST),
        .bus    (bus)
    );

    always #5 CLKBit = ~CLKBit;

    int errors = 0;
    int checks = 0;

    // Reference model state: position in word, bits awaiting the wire,
    // transmitted-payload history for the scrambler, PRBS period table.
    bit seq [127];
    int pos;
    bit q[$];
    bit prev;
    bit hist[$];
    int wordn;
    bit exp_dout;
    bit exp_ws;

    task automatic model_reset();
        pos = 0;
        q.delete();
        repeat (63) q.push_back(1'b0);
        prev = 1'b0;
        hist.delete();
        repeat (58) hist.push_back(1'b0);
        wordn = 0;
    endtask

    task automatic step();
        bit [29:0] p;
        bit [31:0] frame;
        bit        o;
        bit        cap;
        bit        b;
        @(posedge CLKBit);
        #1;
        if (RST) begin
            model_reset();
            exp_dout = 1'b0;
            exp_ws   = 1'b0;
        end else begin
            cap = (pos == 31);
            pos = (pos + 1) % 32;
            if (cap) begin
                for (int i = 0; i < 30; i++)
                    p[i] = bus.REVData ? bus.DataIn[29-i] : bus.DataIn[i];
                frame[31:30] = 2'b10;
                for (int i = 29; i >= 0; i--) begin
                    o = p[i] ^ (bus.ENScr & (hist[hist.size()-1-38] ^ hist[hist.size()-1-57]));
                    hist.push_back(o);
                    void'(hist.pop_front());
                    frame[i] = o;
                end
                if (bus.TestMode)
                    for (int j = 0; j < 32; j++) frame[31-j] = seq[(32*wordn + j) % 127];
                wordn++;
                for (int j = 31; j >= 0; j--) q.push_back(frame[j]);
            end
            b        = q.pop_front();
            exp_dout = bus.REVCLK ? prev : b;
            prev     = b;
            exp_ws   = (pos == 31);
        end
    endtask

    // Advance (unchecked) until the next edge is a capture edge.
    task automatic align();
        for (int k = 0; k < 40 && pos != 31; k++) step();
    endtask

    task automatic set_modes(input bit tm, input bit en, input bit rev, input bit rc);
        bus.TestMode = tm;
        bus.ENScr    = en;
        bus.REVData  = rev;
        bus.REVCLK   = rc;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) begin
            step();
            checks += 2;
            if (bus.DataOut !== 1'b0) begin
                errors++;
                $display("FAIL reset_dataout t=%0t got %b want 0", $time, bus.DataOut);
            end
            if (bus.WordStart !== 1'b0) begin
                errors++;
                $display("FAIL reset_wordstart t=%0t got %b want 0", $time, bus.WordStart);
            end
        end
        RST = 1'b0;
    endtask

    task automatic test_plain_ones();
        bit [31:0] f;
        int        last_ws;
        set_modes(0, 0, 0, 0);
        bus.DataIn = 30'h3FFFFFFF;
        last_ws = -1;
        for (int c = 0; c < 4*32; c++) begin
            step();
            checks += 2;
            if (bus.DataOut !== exp_dout) begin
                errors++;
                $display("FAIL ones_dataout t=%0t got %b want %b", $time, bus.DataOut, exp_dout);
            end
            if (bus.WordStart !== exp_ws) begin
                errors++;
                $display("FAIL ones_wordstart t=%0t got %b want %b", $time, bus.WordStart, exp_ws);
            end
            if (bus.WordStart === 1'b1) begin
                if (last_ws >= 0) begin
                    checks++;
                    if (c - last_ws !== 32) begin
                        errors++;
                        $display("FAIL ws_period got %0d want 32", c - last_ws);
                    end
                end
                last_ws = c;
            end
        end
        align();
        for (int k = 0; k < 32; k++) begin
            step();
            f[31-k] = bus.DataOut;
        end
        checks++;
        if (f !== 32'hBFFFFFFF) begin
            errors++;
            $display("FAIL ones_frame got %h want bfffffff", f);
        end
    endtask

    task automatic test_rev_data();
        bit [31:0] f;
        bit [31:0] want;
        for (int r = 0; r < 2; r++) begin
            set_modes(0, 0, r[0], 0);
            bus.DataIn = 30'h00000001;
            for (int c = 0; c < 3*32; c++) begin
                step();
                checks += 2;
                if (bus.DataOut !== exp_dout) begin
                    errors++;
                    $display("FAIL rev_dataout t=%0t got %b want %b", $time, bus.DataOut, exp_dout);
                end
                if (bus.WordStart !== exp_ws) begin
                    errors++;
                    $display("FAIL rev_wordstart t=%0t got %b want %b", $time, bus.WordStart, exp_ws);
                end
            end
            align();
            for (int k = 0; k < 32; k++) begin
                step();
                f[31-k] = bus.DataOut;
            end
            want = (r == 0) ? 32'h80000001 : 32'hA0000000;
            checks++;
            if (f !== want) begin
                errors++;
                $display("FAIL rev_frame rev=%0d got %h want %h", r, f, want);
            end
        end
    endtask

    task automatic test_scrambler();
        bit [31:0] wins [15];
        bit        rx   [420];
        bit        rxf  [420];
        bit        dx0  [420];
        bit        dx1  [420];
        bit [29:0] dw;
        int        n;
        int        diffs;
        RST = 1'b1;
        step();
        RST = 1'b0;
        set_modes(0, 1, 0, 0);
        bus.DataIn = '0;
        align();
        for (int w = 0; w < 15; w++) begin
            bus.DataIn = 30'(w);
            for (int k = 0; k < 32; k++) begin
                step();
                checks += 2;
                if (bus.DataOut !== exp_dout) begin
                    errors++;
                    $display("FAIL scr_dataout t=%0t got %b want %b", $time, bus.DataOut, exp_dout);
                end
                if (bus.WordStart !== exp_ws) begin
                    errors++;
                    $display("FAIL scr_wordstart t=%0t got %b want %b", $time, bus.WordStart, exp_ws);
                end
                wins[w][31-k] = bus.DataOut;
            end
        end
        // Window m+1 carries the frame built from DataIn = m.
        n = 0;
        for (int m = 0; m < 14; m++) begin
            checks++;
            if (wins[m+1][31:30] !== 2'b10) begin
                errors++;
                $display("FAIL scr_header word=%0d got %b want 10", m, wins[m+1][31:30]);
            end
            for (int i = 29; i >= 0; i--) begin
                rx[n] = wins[m+1][i];
                n++;
            end
        end
        for (int k = 0; k < n; k++) rxf[k] = rx[k];
        rxf[100] = ~rxf[100];
        for (int k = 0; k < n; k++) begin
            dx0[k] = rx[k]  ^ ((k >= 39) ? rx[k-39]  : 1'b0) ^ ((k >= 58) ? rx[k-58]  : 1'b0);
            dx1[k] = rxf[k] ^ ((k >= 39) ? rxf[k-39] : 1'b0) ^ ((k >= 58) ? rxf[k-58] : 1'b0);
        end
        for (int m = 0; m < 14; m++) begin
            for (int i = 0; i < 30; i++) dw[29-i] = dx0[30*m + i];
            checks++;
            if (dw !== 30'(m)) begin
                errors++;
                $display("FAIL descramble word=%0d got %h want %h", m, dw, m);
            end
        end
        diffs = 0;
        for (int k = 0; k < n; k++) if (dx0[k] != dx1[k]) diffs++;
        checks++;
        if (diffs !== 3) begin
            errors++;
            $display("FAIL flip_errors got %0d want 3", diffs);
        end
    endtask

    task automatic test_prbs();
        bit [31:0] w0;
        bit [31:0] w1;
        RST = 1'b1;
        step();
        RST = 1'b0;
        set_modes(1, 0, 0, 0);
        bus.DataIn = 30'($urandom);
        align();
        for (int k = 0; k < 32; k++) begin
            step();
            w0[31-k] = bus.DataOut;
        end
        for (int k = 0; k < 32; k++) begin
            step();
            w1[31-k] = bus.DataOut;
        end
        checks += 2;
        if (w0 !== 32'h0) begin
            errors++;
            $display("FAIL prbs_fill got %h want 00000000", w0);
        end
        if (w1[31:25] !== 7'b0000001) begin
            errors++;
            $display("FAIL prbs_first got %b want 0000001", w1[31:25]);
        end
        for (int c = 0; c < 8*32; c++) begin
            if (c % 32 == 5) bus.DataIn = 30'($urandom);
            step();
            checks += 2;
            if (bus.DataOut !== exp_dout) begin
                errors++;
                $display("FAIL prbs_dataout t=%0t got %b want %b", $time, bus.DataOut, exp_dout);
            end
            if (bus.WordStart !== exp_ws) begin
                errors++;
                $display("FAIL prbs_wordstart t=%0t got %b want %b", $time, bus.WordStart, exp_ws);
            end
        end
    endtask

    task automatic test_revclk();
        bit [63:0] r0;
        bit [63:0] r1;
        set_modes(0, 0, 0, 0);
        bus.DataIn = 30'($urandom);
        for (int c = 0; c < 3*32; c++) step();
        align();
        for (int r = 0; r < 2; r++) begin
            bus.REVCLK = r[0];
            for (int k = 0; k < 64; k++) begin
                step();
                checks++;
                if (bus.DataOut !== exp_dout) begin
                    errors++;
                    $display("FAIL revclk_dataout t=%0t got %b want %b", $time, bus.DataOut, exp_dout);
                end
                if (r == 0) r0[63-k] = bus.DataOut;
                else        r1[63-k] = bus.DataOut;
            end
        end
        checks++;
        if (r1 !== {r0[0], r0[63:1]}) begin
            errors++;
            $display("FAIL revclk_shift got %h want %h", r1, {r0[0], r0[63:1]});
        end
        bus.REVCLK = 1'b0;
    endtask

    task automatic test_random_modes();
        for (int c = 0; c < 400; c++) begin
            bus.DataIn = 30'($urandom);
            if ($urandom_range(0, 15) == 0)
                set_modes(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            step();
            checks += 2;
            if (bus.DataOut !== exp_dout) begin
                errors++;
                $display("FAIL rand_dataout t=%0t got %b want %b", $time, bus.DataOut, exp_dout);
            end
            if (bus.WordStart !== exp_ws) begin
                errors++;
                $display("FAIL rand_wordstart t=%0t got %b want %b", $time, bus.WordStart, exp_ws);
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit ws_prev;
        int first_cap;
        set_modes(0, 1, 0, 0);
        for (int k = 0; k < 40 && pos != 13; k++) step();
        RST = 1'b1;
        bus.TestMode = 1'b1;
        repeat (3) begin
            step();
            checks += 2;
            if (bus.DataOut !== 1'b0) begin
                errors++;
                $display("FAIL midrst_dataout t=%0t got %b want 0", $time, bus.DataOut);
            end
            if (bus.WordStart !== 1'b0) begin
                errors++;
                $display("FAIL midrst_wordstart t=%0t got %b want 0", $time, bus.WordStart);
            end
        end
        RST = 1'b0;
        first_cap = -1;
        for (int n = 1; n <= 3*32; n++) begin
            ws_prev = bus.WordStart;
            step();
            if (ws_prev === 1'b1 && first_cap < 0) first_cap = n;
            checks += 2;
            if (bus.DataOut !== exp_dout) begin
                errors++;
                $display("FAIL postrst_dataout t=%0t got %b want %b", $time, bus.DataOut, exp_dout);
            end
            if (bus.WordStart !== exp_ws) begin
                errors++;
                $display("FAIL postrst_wordstart t=%0t got %b want %b", $time, bus.WordStart, exp_ws);
            end
        end
        checks++;
        if (first_cap !== 32) begin
            errors++;
            $display("FAIL first_capture_edge got %0d want 32", first_cap);
        end
    endtask

    initial begin
        bit [6:0] s;
        bit       b;
        s = 7'h7F;
        for (int k = 0; k < 127; k++) begin
            b      = s[6] ^ s[5];
            seq[k] = b;
            s      = {s[5:0], b};
        end
        RST = 1'b1;
        set_modes(0, 0, 0, 0);
        bus.DataIn = '0;
        model_reset();

        test_reset();
        test_plain_ones();
        test_rev_data();
        test_scrambler();
        test_prbs();
        test_revclk();
        test_random_modes();
        test_reset_midframe();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
